// File: rtl/uart_loader_pkg.sv
// Shared definitions for the UART boot loader: FSM states, error codes and default start byte.
package uart_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CNT_LO,
      CNT_HI,
      DATA,
      CHECK,
      DONE,
      ERROR
   } state_t;

   localparam logic [2:0] ERR_NONE    = 3'd0;
   localparam logic [2:0] ERR_LINE    = 3'd1;
   localparam logic [2:0] ERR_LEN     = 3'd2;
   localparam logic [2:0] ERR_CSUM    = 3'd3;
   localparam logic [2:0] ERR_TIMEOUT = 3'd4;

   localparam logic [7:0] DEFAULT_MAGIC = 8'hA5;

endpackage

// File: rtl/uart_loader_timer.sv
// Inter-byte idle counter; pulses timeout on the clock where the idle count reaches TIMEOUT.
module uart_loader_timer #(
   parameter int TIMEOUT = 1000000,
   parameter int TO_W    = 20
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic timeout
);

   logic [TO_W-1:0] count_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_reg <= '0;
      end else if (clr || !en) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_reg + 1'b1;
      end
   end

   // A byte in the same cycle always beats the timeout.
   assign timeout = en && !clr && (count_reg == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/uart_loader.sv
// Parses MAGIC/count/words/checksum packets from the UART and writes little-endian words to memory.
module uart_loader
   import uart_loader_pkg::*;
#(
   parameter int         ADDR_W    = 8,
   parameter int         BASE_ADDR = 0,
   parameter logic [7:0] MAGIC     = DEFAULT_MAGIC,
   parameter int         TIMEOUT   = 1000000,
   parameter int         TO_W      = 20,
   parameter bit         PARITY_EN = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        rx_data,
   input  logic              rx_rdsig,
   input  logic              rx_dataerror,
   input  logic              rx_frameerror,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [2:0]        err_code
);

   localparam longint MAX_WORDS = (longint'(1) << ADDR_W) - longint'(BASE_ADDR);

   state_t      state_reg;
   logic        rdsig_q;
   logic [7:0]  count_lo_reg;
   logic [15:0] count_reg;
   logic [15:0] word_idx_reg;
   logic [1:0]  byte_idx_reg;
   logic [7:0]  csum_reg;
   logic [23:0] word_reg;

   logic        byte_ev;
   logic        bad_byte;
   logic        active;
   logic        timeout;
   logic [15:0] count_full;

   assign byte_ev    = rdsig_q && !rx_rdsig;
   assign bad_byte   = rx_frameerror || (PARITY_EN && rx_dataerror);
   assign active     = (state_reg == CNT_LO) || (state_reg == CNT_HI) ||
                       (state_reg == DATA)   || (state_reg == CHECK);
   assign count_full = {rx_data, count_lo_reg};

   uart_loader_timer #(
      .TIMEOUT (TIMEOUT),
      .TO_W    (TO_W)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clr     (byte_ev),
      .en      (active),
      .timeout (timeout)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= IDLE;
         rdsig_q      <= 1'b0;
         count_lo_reg <= '0;
         count_reg    <= '0;
         word_idx_reg <= '0;
         byte_idx_reg <= '0;
         csum_reg     <= '0;
         word_reg     <= '0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         cpu_hold     <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         err          <= 1'b0;
         err_code     <= ERR_NONE;
      end else begin
         rdsig_q <= rx_rdsig;
         mem_we  <= 1'b0;
         if (byte_ev) begin
            if (bad_byte) begin
               // Line errors only matter once a packet has started.
               if (active) begin
                  state_reg <= ERROR;
                  err       <= 1'b1;
                  err_code  <= ERR_LINE;
                  busy      <= 1'b0;
               end
            end else begin
               case (state_reg)
                  IDLE, DONE, ERROR: begin
                     if (rx_data == MAGIC) begin
                        state_reg    <= CNT_LO;
                        busy         <= 1'b1;
                        cpu_hold     <= 1'b1;
                        done         <= 1'b0;
                        err          <= 1'b0;
                        err_code     <= ERR_NONE;
                        word_idx_reg <= '0;
                        byte_idx_reg <= '0;
                        csum_reg     <= '0;
                     end
                  end
                  CNT_LO: begin
                     count_lo_reg <= rx_data;
                     state_reg    <= CNT_HI;
                  end
                  CNT_HI: begin
                     count_reg <= count_full;
                     if (longint'(count_full) > MAX_WORDS) begin
                        state_reg <= ERROR;
                        err       <= 1'b1;
                        err_code  <= ERR_LEN;
                        busy      <= 1'b0;
                     end else if (count_full == 16'd0) begin
                        state_reg <= CHECK;
                     end else begin
                        state_reg <= DATA;
                     end
                  end
                  DATA: begin
                     csum_reg     <= csum_reg + rx_data;
                     byte_idx_reg <= byte_idx_reg + 2'd1;
                     if (byte_idx_reg == 2'd3) begin
                        mem_we       <= 1'b1;
                        mem_addr     <= ADDR_W'(BASE_ADDR + int'(word_idx_reg));
                        mem_wdata    <= {rx_data, word_reg};
                        word_idx_reg <= word_idx_reg + 16'd1;
                        if ({1'b0, word_idx_reg} + 17'd1 == {1'b0, count_reg}) begin
                           state_reg <= CHECK;
                        end
                     end else begin
                        word_reg[byte_idx_reg*8 +: 8] <= rx_data;
                     end
                  end
                  CHECK: begin
                     if (rx_data == csum_reg) begin
                        state_reg <= DONE;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        cpu_hold  <= 1'b0;
                     end else begin
                        state_reg <= ERROR;
                        err       <= 1'b1;
                        err_code  <= ERR_CSUM;
                        busy      <= 1'b0;
                     end
                  end
                  default: state_reg <= IDLE;
               endcase
            end
         end else if (timeout) begin
            state_reg <= ERROR;
            err       <= 1'b1;
            err_code  <= ERR_TIMEOUT;
            busy      <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_loader.sv
// Self-checking bench for uart_loader: directed packet table, corner sequences, random packets vs model.
module tb_uart_loader;

   localparam int ADDR_W  = 8;
   localparam int TIMEOUT = 100;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [7:0]        rx_data = 8'h00;
   logic              rx_rdsig = 1'b0;
   logic              rx_dataerror = 1'b0;
   logic              rx_frameerror = 1'b0;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              cpu_hold, busy, done, err;
   logic [2:0]        err_code;

   uart_loader #(
      .ADDR_W    (ADDR_W),
      .BASE_ADDR (0),
      .MAGIC     (8'hA5),
      .TIMEOUT   (TIMEOUT),
      .TO_W      (20),
      .PARITY_EN (1'b1)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .rx_data       (rx_data),
      .rx_rdsig      (rx_rdsig),
      .rx_dataerror  (rx_dataerror),
      .rx_frameerror (rx_frameerror),
      .mem_we        (mem_we),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .cpu_hold      (cpu_hold),
      .busy          (busy),
      .done          (done),
      .err           (err),
      .err_code      (err_code)
   );

   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_miss = 0;

   logic [39:0] wr_q[$];
   logic [39:0] exp_q[$];
   logic [7:0]  pkt_q[$];
   int          fault_idx;
   logic        fault_par;

   always @(negedge clk) begin
      if (mem_we) wr_q.push_back({mem_addr, mem_wdata});
   end

   typedef struct packed {
      logic [95:0] bytes;     // byte 0 in the top octet
      logic [3:0]  n;
      logic [3:0]  fidx;      // 15 = no faulty byte
      logic        fpar;
      logic [1:0]  n_wr;
      logic [31:0] w0;
      logic [31:0] w1;
      logic        e_done;
      logic        e_err;
      logic [2:0]  e_code;
      logic        e_hold;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rx_rdsig = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      wr_q.delete();
   endtask

   task automatic send_byte(input logic [7:0] b, input logic fe, input logic pe);
      @(negedge clk);
      rx_data       = b;
      rx_frameerror = fe;
      rx_dataerror  = pe;
      rx_rdsig      = 1'b1;
      repeat (2) @(negedge clk);
      rx_rdsig = 1'b0;
      repeat (2) @(negedge clk);
      rx_frameerror = 1'b0;
      rx_dataerror  = 1'b0;
   endtask

   task automatic send_pkt();
      foreach (pkt_q[i]) begin
         send_byte(pkt_q[i], (i == fault_idx) && !fault_par, (i == fault_idx) && fault_par);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic check_final(input string tag, input logic e_done, input logic e_err,
                              input logic [2:0] e_code, input logic e_hold);
      int n;
      chk({tag, " done"}, 40'(done), 40'(e_done));
      chk({tag, " err"}, 40'(err), 40'(e_err));
      chk({tag, " err_code"}, 40'(err_code), 40'(e_code));
      chk({tag, " cpu_hold"}, 40'(cpu_hold), 40'(e_hold));
      chk({tag, " busy"}, 40'(busy), 40'(1'b0));
      chk({tag, " n_writes"}, 40'(wr_q.size()), 40'(exp_q.size()));
      n = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) chk({tag, " write"}, wr_q[i], exp_q[i]);
   endtask

   initial begin
      int cnt, len, iters;
      logic [7:0] sum, chkb;
      logic [7:0] dat[$];
      logic bad;

      vecs[0] = '{96'hA5_02_00_78_56_34_12_EF_BE_AD_DE_4C, 4'd12, 4'd15, 1'b0, 2'd2,
                  32'h12345678, 32'hDEADBEEF, 1'b1, 1'b0, 3'd0, 1'b0};
      vecs[1] = '{96'hA5_02_00_78_56_34_12_EF_BE_AD_DE_4D, 4'd12, 4'd15, 1'b0, 2'd2,
                  32'h12345678, 32'hDEADBEEF, 1'b0, 1'b1, 3'd3, 1'b1};
      vecs[2] = '{96'hA5_00_00_00_00_00_00_00_00_00_00_00, 4'd4, 4'd15, 1'b0, 2'd0,
                  32'h0, 32'h0, 1'b1, 1'b0, 3'd0, 1'b0};
      vecs[3] = '{96'hA5_01_01_00_00_00_00_00_00_00_00_00, 4'd3, 4'd15, 1'b0, 2'd0,
                  32'h0, 32'h0, 1'b0, 1'b1, 3'd2, 1'b1};
      vecs[4] = '{96'hA5_01_00_11_22_00_00_00_00_00_00_00, 4'd5, 4'd4, 1'b0, 2'd0,
                  32'h0, 32'h0, 1'b0, 1'b1, 3'd1, 1'b1};
      vecs[5] = '{96'hA5_00_00_00_00_00_00_00_00_00_00_00, 4'd1, 4'd0, 1'b0, 2'd0,
                  32'h0, 32'h0, 1'b0, 1'b0, 3'd0, 1'b0};
      vecs[6] = '{96'hA5_01_00_11_22_33_44_AA_00_00_00_00, 4'd8, 4'd3, 1'b1, 2'd0,
                  32'h0, 32'h0, 1'b0, 1'b1, 3'd1, 1'b1};
      vecs[7] = '{96'hA5_01_00_01_02_03_04_0A_00_00_00_00, 4'd8, 4'd15, 1'b0, 2'd1,
                  32'h04030201, 32'h0, 1'b1, 1'b0, 3'd0, 1'b0};

      // Reset values while rst is held.
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst mem_we", 40'(mem_we), 40'(0));
      chk("rst mem_addr", 40'(mem_addr), 40'(0));
      chk("rst mem_wdata", 40'(mem_wdata), 40'(0));
      chk("rst flags", 40'({cpu_hold, busy, done, err, err_code}), 40'(0));
      rst = 1'b0;

      for (int v = 0; v < 8; v++) begin
         do_reset();
         pkt_q.delete();
         exp_q.delete();
         for (int i = 0; i < int'(vecs[v].n); i++) pkt_q.push_back(vecs[v].bytes[95-8*i -: 8]);
         fault_idx = (vecs[v].fidx == 4'd15) ? -1 : int'(vecs[v].fidx);
         fault_par = vecs[v].fpar;
         if (vecs[v].n_wr > 0) exp_q.push_back({8'd0, vecs[v].w0});
         if (vecs[v].n_wr > 1) exp_q.push_back({8'd1, vecs[v].w1});
         send_pkt();
         $display("vec %0d: %0d bytes, err_code=%0d done=%0d writes=%0d",
                  v, pkt_q.size(), err_code, done, wr_q.size());
         check_final($sformatf("vec%0d", v), vecs[v].e_done, vecs[v].e_err,
                     vecs[v].e_code, vecs[v].e_hold);
      end

      // Timeout after A5 02 00 78, then restart with a fresh MAGIC.
      do_reset();
      fault_idx = -1;
      send_byte(8'hA5, 1'b0, 1'b0);
      chk("mid busy", 40'(busy), 40'(1));
      chk("mid cpu_hold", 40'(cpu_hold), 40'(1));
      send_byte(8'h02, 1'b0, 1'b0);
      send_byte(8'h00, 1'b0, 1'b0);
      send_byte(8'h78, 1'b0, 1'b0);
      repeat (90) @(negedge clk);
      chk("to early err", 40'(err), 40'(0));
      iters = 0;
      while (!err && iters < 20) begin
         @(negedge clk);
         iters++;
      end
      chk("to latency", 40'(iters), 40'(9));
      chk("to err_code", 40'(err_code), 40'(4));
      chk("to cpu_hold", 40'(cpu_hold), 40'(1));
      send_byte(8'hA5, 1'b0, 1'b0);
      chk("restart err", 40'({err, err_code}), 40'(0));
      chk("restart busy", 40'(busy), 40'(1));
      $display("timeout seq: latency=%0d", iters);

      // Reset mid-load releases the CPU without any write.
      send_byte(8'h01, 1'b0, 1'b0);
      send_byte(8'h00, 1'b0, 1'b0);
      send_byte(8'h11, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst flags", 40'({cpu_hold, busy, done, err}), 40'(0));
      rst = 1'b0;
      chk("midrst writes", 40'(wr_q.size()), 40'(0));
      $display("mid-load reset seq");

      // Random packets against a packet-level model.
      for (int t = 0; t < 24; t++) begin
         do_reset();
         pkt_q.delete();
         exp_q.delete();
         dat.delete();
         cnt = ($urandom_range(0, 5) == 5) ? int'($urandom_range(257, 400)) : int'($urandom_range(0, 4));
         pkt_q.push_back(8'hA5);
         pkt_q.push_back(cnt[7:0]);
         pkt_q.push_back(cnt[15:8]);
         sum = 8'h00;
         bad = ($urandom_range(0, 3) == 0);
         if (cnt <= 256) begin
            for (int i = 0; i < 4 * cnt; i++) begin
               dat.push_back(8'($urandom));
               pkt_q.push_back(dat[i]);
               sum = sum + dat[i];
            end
            chkb = bad ? sum + 8'($urandom_range(1, 255)) : sum;
            pkt_q.push_back(chkb);
         end
         len = pkt_q.size();
         fault_idx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, len - 1)) : -1;
         fault_par = 1'($urandom);
         if (cnt <= 256) begin
            for (int w = 0; w < cnt; w++) begin
               if (fault_idx < 0 || 6 + 4 * w < fault_idx)
                  exp_q.push_back({8'(w), dat[4*w+3], dat[4*w+2], dat[4*w+1], dat[4*w]});
            end
         end
         send_pkt();
         $display("rand %0d: cnt=%0d fault=%0d bad_csum=%0d err_code=%0d writes=%0d",
                  t, cnt, fault_idx, bad, err_code, wr_q.size());
         if (fault_idx >= 0)  check_final($sformatf("rand%0d", t), 1'b0, 1'b1, 3'd1, 1'b1);
         else if (cnt > 256)  check_final($sformatf("rand%0d", t), 1'b0, 1'b1, 3'd2, 1'b1);
         else if (bad)        check_final($sformatf("rand%0d", t), 1'b0, 1'b1, 3'd3, 1'b1);
         else                 check_final($sformatf("rand%0d", t), 1'b1, 1'b0, 3'd0, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
